// File: rtl/cbus_axi_bridge.sv
// CBus-to-AXI3/4 master bridge: one CBus burst becomes one AXI INCR burst, single outstanding.
// Define CBUS_AXI_ERR_EN to add the sticky cresp_err response flag.
module cbus_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int AXI_ID = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                creq_valid,
  input  logic                creq_is_write,
  input  logic [2:0]          creq_size,
  input  logic [ADDR_W-1:0]   creq_addr,
  input  logic [LEN_W-1:0]    creq_len,
  input  logic [DATA_W/8-1:0] creq_strobe,
  input  logic [DATA_W-1:0]   creq_data,
  output logic                cresp_ready,
  output logic                cresp_last,
  output logic [DATA_W-1:0]   cresp_data,
`ifdef CBUS_AXI_ERR_EN
  output logic                cresp_err,
`endif
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [LEN_W-1:0]    arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [2:0]        r_size;
  logic              w_last_beat;
  logic              w_unused;

  assign w_last_beat = (r_cnt == r_len);
  // IDs are not checked with a single transaction in flight.
  assign w_unused    = ^{1'b0, rid, bid, rresp, bresp};

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (creq_valid) w_next = creq_is_write ? S_AW : S_AR;
        else            w_next = S_IDLE;
      end
      S_AR:   if (arready)                  w_next = S_R;    else w_next = S_AR;
      S_R:    if (rvalid && rlast)          w_next = S_IDLE; else w_next = S_R;
      S_AW:   if (awready)                  w_next = S_W;    else w_next = S_AW;
      S_W:    if (wready && w_last_beat)    w_next = S_B;    else w_next = S_W;
      S_B:    if (bvalid)                   w_next = S_IDLE; else w_next = S_B;
      default: w_next = S_IDLE;
    endcase
  end

  // State, request latches and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (creq_valid) begin
          r_addr <= creq_addr;
          r_len  <= creq_len;
          r_size <= creq_size;
          r_cnt  <= '0;
        end
        S_R:     if (rvalid) r_cnt <= r_cnt + 1'b1;
        S_W:     if (wready && !w_last_beat) r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign arid    = ID_W'(AXI_ID);
  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arsize  = r_size;
  assign arburst = 2'b01;
  assign arvalid = (r_state == S_AR);
  assign rready  = (r_state == S_R);

  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = r_addr;
  assign awlen   = r_len;
  assign awsize  = r_size;
  assign awburst = 2'b01;
  assign awvalid = (r_state == S_AW);

  assign wid     = ID_W'(AXI_ID);
  assign wdata   = creq_data;
  assign wstrb   = creq_strobe;
  assign wvalid  = (r_state == S_W);
  assign wlast   = wvalid && w_last_beat;
  assign bready  = (r_state == S_B);

  // The final write beat is acknowledged by the B response, not by wready.
  assign cresp_ready = (rready && rvalid) || (wvalid && wready && !w_last_beat) || (bready && bvalid);
  assign cresp_last  = (rready && rvalid && rlast) || (bready && bvalid);
  assign cresp_data  = rdata;

`ifdef CBUS_AXI_ERR_EN
  logic r_err;
  logic w_err_now;

  assign w_err_now = (rready && rvalid && ((rresp != 2'b00) || (rlast && !w_last_beat)))
                   || (bready && bvalid && (bresp != 2'b00));
  assign cresp_err = cresp_last && (r_err || w_err_now);

  // Sticky error flag for the burst in progress
  always_ff @(posedge clk) begin
    if (reset)                 r_err <= 1'b0;
    else if (r_state == S_IDLE) r_err <= 1'b0;
    else if (w_err_now)        r_err <= 1'b1;
    else                       r_err <= r_err;
  end
`endif

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Directed self-checking bench for cbus_axi_bridge; inputs change and outputs are checked on the falling edge.
module tb_cbus_axi_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        creq_valid, creq_is_write;
  logic [2:0]  creq_size;
  logic [31:0] creq_addr;
  logic [3:0]  creq_len;
  logic [3:0]  creq_strobe;
  logic [31:0] creq_data;
  logic        cresp_ready, cresp_last;
  logic [31:0] cresp_data;
`ifdef CBUS_AXI_ERR_EN
  logic        cresp_err;
`endif
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cbus_axi_bridge dut (
    .clk(clk), .reset(reset),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_len(creq_len), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
`ifdef CBUS_AXI_ERR_EN
    .cresp_err(cresp_err),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic drive_req(input logic wr, input logic [31:0] a, input logic [3:0] l);
    creq_valid = 1'b1; creq_is_write = wr; creq_addr = a; creq_len = l; creq_size = 3'd2;
  endtask

  task automatic test_reset();
    reset = 1'b1; creq_valid = 1'b0; creq_is_write = 1'b0; creq_size = 3'd0; creq_addr = 32'h0;
    creq_len = 4'd0; creq_strobe = 4'h0; creq_data = 32'h0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rdata = 32'h0; rresp = 2'b00; bresp = 2'b00; rid = 4'h0; bid = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({arvalid, awvalid, wvalid, wlast, rready, bready, cresp_ready, cresp_last} !== 8'h00) begin
      errors++; $display("FAIL rst_ctrl got=%b exp=00000000", {arvalid, awvalid, wvalid, wlast, rready, bready, cresp_ready, cresp_last}); end
    checks++; if ({araddr, arlen, arsize} !== 39'h0) begin
      errors++; $display("FAIL rst_regs got=%h/%h/%h exp=0", araddr, arlen, arsize); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_read();
    @(negedge clk); drive_req(1'b0, 32'h1FC0_0000, 4'd3); #1;
    checks++; if ({arvalid, awvalid, rready} !== 3'b000) begin
      errors++; $display("FAIL rd_idle_quiet got=%b exp=000", {arvalid, awvalid, rready}); end
    @(negedge clk); #1;
    checks++; if ({arvalid, araddr, arlen, arsize, arburst} !== {1'b1, 32'h1FC0_0000, 4'd3, 3'd2, 2'b01}) begin
      errors++; $display("FAIL rd_ar got=%b %h %h %h %b exp=1 1fc00000 3 2 01", arvalid, araddr, arlen, arsize, arburst); end
    @(negedge clk); #1;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rd_ar_hold got=%b exp=1", arvalid); end
    @(negedge clk); arready = 1'b1;
    @(negedge clk); arready = 1'b0; #1;
    checks++; if ({arvalid, rready, cresp_ready} !== 3'b010) begin
      errors++; $display("FAIL rd_r_gap got=%b exp=010", {arvalid, rready, cresp_ready}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rvalid = 1'b1; rdata = 32'hA0 + i; rlast = (i == 3); #1;
      checks++; if ({cresp_ready, cresp_last, cresp_data} !== {1'b1, (i == 3), 32'hA0 + i}) begin
        errors++; $display("FAIL rd_beat%0d got=%b%b %h exp=1%0d %h", i, cresp_ready, cresp_last, cresp_data, (i == 3), 32'hA0 + i); end
    end
    @(negedge clk); rvalid = 1'b0; rlast = 1'b0; creq_valid = 1'b0; #1;
    checks++; if ({rready, arvalid, cresp_ready} !== 3'b000) begin
      errors++; $display("FAIL rd_done got=%b exp=000", {rready, arvalid, cresp_ready}); end
  endtask

  task automatic test_write_single();
    @(negedge clk); drive_req(1'b1, 32'h0000_0100, 4'd0); creq_data = 32'hDEAD_BEEF; creq_strobe = 4'b0011;
    @(negedge clk); awready = 1'b1; #1;
    checks++; if ({awvalid, wvalid, awaddr, awlen, awburst} !== {1'b1, 1'b0, 32'h100, 4'd0, 2'b01}) begin
      errors++; $display("FAIL wr1_aw got=%b%b %h %h %b exp=10 100 0 01", awvalid, wvalid, awaddr, awlen, awburst); end
    @(negedge clk); awready = 1'b0; wready = 1'b1; #1;
    checks++; if ({wvalid, wlast, awvalid, cresp_ready, wdata, wstrb} !== {4'b1100, 32'hDEAD_BEEF, 4'b0011}) begin
      errors++; $display("FAIL wr1_w got=%b%b%b%b %h %b exp=1100 deadbeef 0011", wvalid, wlast, awvalid, cresp_ready, wdata, wstrb); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); wready = 1'b0; #1;
      checks++; if ({bready, wvalid, cresp_ready, cresp_last} !== 4'b1000) begin
        errors++; $display("FAIL wr1_bwait%0d got=%b exp=1000", i, {bready, wvalid, cresp_ready, cresp_last}); end
    end
    @(negedge clk); bvalid = 1'b1; #1;
    checks++; if ({cresp_ready, cresp_last} !== 2'b11) begin
      errors++; $display("FAIL wr1_b got=%b exp=11", {cresp_ready, cresp_last}); end
    @(negedge clk); bvalid = 1'b0; creq_valid = 1'b0; #1;
    checks++; if ({bready, cresp_ready} !== 2'b00) begin
      errors++; $display("FAIL wr1_done got=%b exp=00", {bready, cresp_ready}); end
  endtask

  task automatic test_write_burst();
    int  beat = 0;
    int  acks = 0;
    bit  done = 1'b0;
    bit  tog  = 1'b0;
    @(negedge clk); drive_req(1'b1, 32'h0000_4000, 4'd7); creq_strobe = 4'hF;
    @(negedge clk); awready = 1'b1; #1;
    checks++; if ({awvalid, awlen} !== {1'b1, 4'd7}) begin
      errors++; $display("FAIL wr8_aw got=%b %h exp=1 7", awvalid, awlen); end
    @(negedge clk); awready = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      wready = tog; creq_data = 32'h1000 + beat; #1;
      checks++; if ({wvalid, wlast, wdata} !== {1'b1, (beat == 7), 32'h1000 + beat}) begin
        errors++; $display("FAIL wr8_w%0d got=%b%b %h exp=1%0d %h", beat, wvalid, wlast, wdata, (beat == 7), 32'h1000 + beat); end
      checks++; if (cresp_ready !== (tog && beat != 7)) begin
        errors++; $display("FAIL wr8_ack%0d got=%b exp=%0d", beat, cresp_ready, (tog && beat != 7)); end
      if (cresp_ready === 1'b1) acks++;
      if (tog) begin
        if (beat == 7) done = 1'b1;
        beat++;
      end
      tog = ~tog;
      @(negedge clk);
    end
    wready = 1'b0; bvalid = 1'b1; #1;
    checks++; if ({done, cresp_ready, cresp_last, bready} !== 4'b1111) begin
      errors++; $display("FAIL wr8_b got=%b exp=1111", {done, cresp_ready, cresp_last, bready}); end
    checks++; if (acks !== 7) begin errors++; $display("FAIL wr8_acks got=%0d exp=7", acks); end
    @(negedge clk); bvalid = 1'b0; creq_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive_req(1'b0, 32'h0000_2000, 4'd0);
    @(negedge clk); arready = 1'b1;
    @(negedge clk); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55;
    creq_is_write = 1'b1; creq_addr = 32'h0000_3000; creq_data = 32'hCAFE_0001; creq_strobe = 4'hF; #1;
    checks++; if ({cresp_ready, cresp_last, cresp_data} !== {2'b11, 32'h55}) begin
      errors++; $display("FAIL b2b_rlast got=%b%b %h exp=11 55", cresp_ready, cresp_last, cresp_data); end
    @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
    checks++; if ({arvalid, awvalid, rready, wvalid} !== 4'b0000) begin
      errors++; $display("FAIL b2b_idle got=%b exp=0000", {arvalid, awvalid, rready, wvalid}); end
    @(negedge clk); awready = 1'b1; #1;
    checks++; if ({awvalid, awaddr} !== {1'b1, 32'h3000}) begin
      errors++; $display("FAIL b2b_aw got=%b %h exp=1 3000", awvalid, awaddr); end
    @(negedge clk); awready = 1'b0; wready = 1'b1;
    @(negedge clk); wready = 1'b0; bvalid = 1'b1; #1;
    checks++; if ({cresp_ready, cresp_last} !== 2'b11) begin
      errors++; $display("FAIL b2b_b got=%b exp=11", {cresp_ready, cresp_last}); end
    @(negedge clk); bvalid = 1'b0; creq_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lasts = 0;
    @(negedge clk); drive_req(1'b0, 32'h0000_5000, 4'd3);
    @(negedge clk); arready = 1'b1;
    @(negedge clk); arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'hB0 + i; rlast = 1'b0;
      @(negedge clk);
    end
    rvalid = 1'b0; reset = 1'b1; creq_valid = 1'b0;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if ({rready, arvalid, cresp_ready, arlen} !== {3'b000, 4'd0}) begin
      errors++; $display("FAIL rstmid_idle got=%b %h exp=000 0", {rready, arvalid, cresp_ready}, arlen); end
    @(negedge clk); drive_req(1'b0, 32'h0000_6000, 4'd3);
    @(negedge clk); arready = 1'b1; #1;
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h6000}) begin
      errors++; $display("FAIL rstmid_ar got=%b %h exp=1 6000", arvalid, araddr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = 32'hC0 + i; rlast = (i == 3); #1;
      checks++; if ({cresp_ready, cresp_data} !== {1'b1, 32'hC0 + i}) begin
        errors++; $display("FAIL rstmid_beat%0d got=%b %h exp=1 %h", i, cresp_ready, cresp_data, 32'hC0 + i); end
      if (cresp_last === 1'b1) lasts++;
    end
    checks++; if (lasts !== 1) begin errors++; $display("FAIL rstmid_last got=%0d exp=1", lasts); end
    @(negedge clk); rvalid = 1'b0; rlast = 1'b0; creq_valid = 1'b0;
  endtask

`ifdef CBUS_AXI_ERR_EN
  task automatic test_err();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); drive_req(1'b0, 32'h0000_7000, 4'd3);
      @(negedge clk); arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = 32'hE0 + i; rlast = (i == 3);
        rresp = (pass == 0 && i == 1) ? 2'b10 : 2'b00; #1;
      end
      checks++; if ({cresp_last, cresp_err} !== {1'b1, (pass == 0)}) begin
        errors++; $display("FAIL err_pass%0d got=%b%b exp=1%0d", pass, cresp_last, cresp_err, (pass == 0)); end
      @(negedge clk); rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; creq_valid = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_single();
    test_write_burst();
    test_back_to_back();
    test_reset_mid();
`ifdef CBUS_AXI_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
